// File: rtl/score_bcd_latch.sv
`default_nettype none
// ============================================================================
//  Module      : score_bcd_latch
//  Description : Samples the signed 32-bit score periodically or on request,
//                clamps it to 0..MAX_SCORE and converts it to three BCD
//                digits with a sequential shift-add-3 engine. The digits are
//                held stable between updates.
//                Optional macro SCORE_BCD_SEVSEG_EN adds registered active-low
//                seven-segment encodings with leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_latch #(
    parameter int SAMPLE_PERIOD = 16,
    parameter int MAX_SCORE     = 999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] score_in,
    input  logic        sample_now,
    output logic [3:0]  bcd_ones,
    output logic [3:0]  bcd_tens,
    output logic [3:0]  bcd_hundreds,
    output logic        update_pulse,
    output logic        overflow,
    output logic        busy,
    output logic [6:0]  seg_ones,
    output logic [6:0]  seg_tens,
    output logic [6:0]  seg_hundreds
);

    localparam logic [0:0]  c_IDLE     = 1'b0;
    localparam logic [0:0]  c_CONV     = 1'b1;
    localparam logic [15:0] c_CNT_LAST = 16'(SAMPLE_PERIOD - 1);
    localparam logic [9:0]  c_MAX      = 10'(MAX_SCORE);
    localparam logic [3:0]  c_LAST_IT  = 4'd9;

    logic [0:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_pending;
    logic [3:0]  r_iter;
    logic [9:0]  r_shift;
    logic [11:0] r_scratch;
    logic        r_ovf_next;
    logic [3:0]  r_ones;
    logic [3:0]  r_tens;
    logic [3:0]  r_hundreds;
    logic        r_ovf;
    logic        r_update;
    logic        r_busy;

    logic        w_tick;
    logic        w_request;
    logic        w_done;
    logic [9:0]  w_clamped;
    logic        w_clamp_ovf;
    logic [11:0] w_adj;
    logic [11:0] w_scratch_next;
    logic [9:0]  w_shift_next;
    logic        w_unused_carry;

    assign w_tick    = (r_cnt == c_CNT_LAST);
    assign w_request = w_tick | sample_now;
    assign w_done    = (r_state == c_CONV) && (r_iter == c_LAST_IT);

    // Free-running sample period counter; sample_now never disturbs it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Clamp the signed score into the displayable range and flag saturation.
    always_comb begin
        w_clamped   = score_in[9:0];
        w_clamp_ovf = 1'b0;
        if (score_in[31]) begin
            w_clamped = '0;
        end else if (score_in[30:0] > 31'(MAX_SCORE)) begin
            w_clamped   = c_MAX;
            w_clamp_ovf = 1'b1;
        end
    end

    // Add-3 correction on every scratch nibble that is 5 or more.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // One left shift of {scratch, shift}; the hundreds carry-out cannot be
    // set for a 10-bit operand and is dropped.
    assign w_scratch_next = {w_adj[10:0], r_shift[9]};
    assign w_shift_next   = {r_shift[8:0], 1'b0};
    assign w_unused_carry = w_adj[11];

    // Sampling FSM, double-dabble engine and registered digit outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_pending  <= 1'b0;
            r_iter     <= '0;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_ovf_next <= 1'b0;
            r_ones     <= '0;
            r_tens     <= '0;
            r_hundreds <= '0;
            r_ovf      <= 1'b0;
            r_update   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_update <= 1'b0;
            // Requests arriving mid-conversion collapse into one pending flag.
            if ((r_state != c_IDLE) && w_request) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_request || r_pending) begin
                        r_shift    <= w_clamped;
                        r_scratch  <= '0;
                        r_ovf_next <= w_clamp_ovf;
                        r_pending  <= 1'b0;
                        r_iter     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= c_CONV;
                    end
                end
                c_CONV: begin
                    r_scratch <= w_scratch_next;
                    r_shift   <= w_shift_next;
                    r_iter    <= r_iter + 4'd1;
                    if (w_done) begin
                        r_ones     <= w_scratch_next[3:0];
                        r_tens     <= w_scratch_next[7:4];
                        r_hundreds <= w_scratch_next[11:8];
                        r_ovf      <= r_ovf_next;
                        r_update   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bcd_ones     = r_ones;
    assign bcd_tens     = r_tens;
    assign bcd_hundreds = r_hundreds;
    assign overflow     = r_ovf;
    assign update_pulse = r_update;
    assign busy         = r_busy;

`ifdef SCORE_BCD_SEVSEG_EN
    logic [6:0] r_seg_ones;
    logic [6:0] r_seg_tens;
    logic [6:0] r_seg_hundreds;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    // Segment patterns are written together with the digits; leading zeros blank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seg_ones     <= 7'h40;
            r_seg_tens     <= 7'h40;
            r_seg_hundreds <= 7'h40;
        end else if (w_done) begin
            r_seg_ones     <= f_seg(w_scratch_next[3:0]);
            r_seg_tens     <= (w_scratch_next[11:4] == 8'h00) ? 7'h7F
                                                              : f_seg(w_scratch_next[7:4]);
            r_seg_hundreds <= (w_scratch_next[11:8] == 4'h0) ? 7'h7F
                                                             : f_seg(w_scratch_next[11:8]);
        end
    end

    assign seg_ones     = r_seg_ones;
    assign seg_tens     = r_seg_tens;
    assign seg_hundreds = r_seg_hundreds;
`else
    assign seg_ones     = 7'h7F;
    assign seg_tens     = 7'h7F;
    assign seg_hundreds = 7'h7F;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_bcd_latch
//  Description : Self-checking bench for score_bcd_latch. A delay-line
//                scoreboard records the clamped expectation of every sampled
//                score and checks it when update_pulse shows new digits;
//                directed tasks check timing, clamping, request merging,
//                mid-conversion reset and segment outputs.
//                Honours SCORE_BCD_SEVSEG_EN for the segment checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_bcd_latch;

    localparam int c_PERIOD = 16;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       ovf;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] score_in = '0;
    logic        sample_now = 1'b0;
    logic [3:0]  bcd_ones, bcd_tens, bcd_hundreds;
    logic        update_pulse, overflow, busy;
    logic [6:0]  seg_ones, seg_tens, seg_hundreds;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_updates    = 0;

    exp_t q[$];

    score_bcd_latch #(.SAMPLE_PERIOD(c_PERIOD), .MAX_SCORE(999)) dut (
        .clock        (clock),
        .reset        (reset),
        .score_in     (score_in),
        .sample_now   (sample_now),
        .bcd_ones     (bcd_ones),
        .bcd_tens     (bcd_tens),
        .bcd_hundreds (bcd_hundreds),
        .update_pulse (update_pulse),
        .overflow     (overflow),
        .busy         (busy),
        .seg_ones     (seg_ones),
        .seg_tens     (seg_tens),
        .seg_hundreds (seg_hundreds)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [31:0] s);
        exp_t e;
        int   v;
        e.ovf = 1'b0;
        if (s[31]) v = 0;
        else if (s > 32'd999) begin
            v     = 999;
            e.ovf = 1'b1;
        end else v = int'(s);
        e.h = 4'(v / 100);
        e.t = 4'((v / 10) % 10);
        e.o = 4'(v % 10);
        return e;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Delay line: entry 0 is the expectation for the score sampled 10 edges ago.
    always @(posedge clock) begin
        if (reset) q.delete();
        else begin
            q.push_back(model(score_in));
            if (q.size() > 11) q.delete(0);
        end
    end

    // Every visible update must match the score sampled 10 edges earlier.
    always @(negedge clock) begin
        if (!reset && update_pulse) begin
            n_updates++;
            tests_run++;
            if (q.size() != 11) begin
                tests_failed++;
                $display("FAIL sb_history: got %0d entries, required 11", q.size());
            end else if ({bcd_hundreds, bcd_tens, bcd_ones, overflow} !== q[0]) begin
                tests_failed++;
                $display("FAIL sb_digits: got %h%h%h ovf=%b, required %h%h%h ovf=%b",
                         bcd_hundreds, bcd_tens, bcd_ones, overflow,
                         q[0].h, q[0].t, q[0].o, q[0].ovf);
            end
        end
    end

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_conv(input logic [31:0] s, output bit ok);
        bit idle_ok;
        ok = 1'b0;
        wait_idle(idle_ok);
        score_in   = s;
        sample_now = 1'b1;
        @(negedge clock);
        sample_now = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (update_pulse) begin
                ok = idle_ok;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] seg_rst;
`ifdef SCORE_BCD_SEVSEG_EN
        seg_rst = 7'h40;
`else
        seg_rst = 7'h7F;
`endif
        repeat (3) @(negedge clock);
        tests_run++;
        if ({bcd_hundreds, bcd_tens, bcd_ones} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_bcd: got %h, required 000", {bcd_hundreds, bcd_tens, bcd_ones});
        end
        tests_run++;
        if ({overflow, update_pulse, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got ovf/upd/busy=%b, required 000", {overflow, update_pulse, busy});
        end
        tests_run++;
        if ({seg_hundreds, seg_tens, seg_ones} !== {seg_rst, seg_rst, seg_rst}) begin
            tests_failed++;
            $display("FAIL reset_seg: got %h %h %h, required %h each", seg_hundreds, seg_tens, seg_ones, seg_rst);
        end
        reset = 1'b0;
    endtask

    task automatic test_periodic();
        int cnt   = 0;
        int first = -1;
        score_in = 32'd0;
        for (int k = 1; k <= c_PERIOD + 10; k++) begin
            @(negedge clock);
            if (update_pulse) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        tests_run++;
        if (cnt !== 1 || first !== c_PERIOD + 10) begin
            tests_failed++;
            $display("FAIL periodic_update: got %0d updates first at edge %0d, required 1 at edge %0d",
                     cnt, first, c_PERIOD + 10);
        end
        tests_run++;
        if ({bcd_hundreds, bcd_tens, bcd_ones, overflow} !== 13'h0000) begin
            tests_failed++;
            $display("FAIL periodic_digits: got %h%h%h ovf=%b, required 000 ovf=0",
                     bcd_hundreds, bcd_tens, bcd_ones, overflow);
        end
    endtask

    task automatic test_sample_latency();
        bit         ok;
        int         busy_cycles = 0;
        int         upd_at = -1;
        logic [11:0] dig = '0;
        wait_idle(ok);
        score_in   = 32'd457;
        sample_now = 1'b1;
        @(negedge clock);
        sample_now = 1'b0;
        if (busy) busy_cycles++;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (busy) busy_cycles++;
            if (update_pulse && upd_at < 0) begin
                upd_at = k;
                dig    = {bcd_hundreds, bcd_tens, bcd_ones};
            end
        end
        tests_run++;
        if (!ok || upd_at !== 10) begin
            tests_failed++;
            $display("FAIL latency_457: got update at edge %0d, required edge 10", upd_at);
        end
        tests_run++;
        if (dig !== 12'h457) begin
            tests_failed++;
            $display("FAIL digits_457: got %h, required 457", dig);
        end
        tests_run++;
        if (busy_cycles !== 10) begin
            tests_failed++;
            $display("FAIL busy_457: got %0d busy cycles, required 10", busy_cycles);
        end
        @(negedge clock);
        tests_run++;
        if (update_pulse !== 1'b0 || {bcd_hundreds, bcd_tens, bcd_ones} !== 12'h457) begin
            tests_failed++;
            $display("FAIL hold_457: got upd=%b digits %h, required upd=0 digits 457",
                     update_pulse, {bcd_hundreds, bcd_tens, bcd_ones});
        end
    endtask

    task automatic test_clamp();
        bit ok;
        run_conv(32'd1234, ok);
        tests_run++;
        if (!ok || {bcd_hundreds, bcd_tens, bcd_ones, overflow} !== {12'h999, 1'b1}) begin
            tests_failed++;
            $display("FAIL clamp_high: got ok=%b %h%h%h ovf=%b, required 999 ovf=1",
                     ok, bcd_hundreds, bcd_tens, bcd_ones, overflow);
        end
        run_conv(32'hFFFF_FFF6, ok);
        tests_run++;
        if (!ok || {bcd_hundreds, bcd_tens, bcd_ones, overflow} !== 13'h0000) begin
            tests_failed++;
            $display("FAIL clamp_neg: got ok=%b %h%h%h ovf=%b, required 000 ovf=0",
                     ok, bcd_hundreds, bcd_tens, bcd_ones, overflow);
        end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          cnt = 0;
        int          first = -1;
        logic        busy_gap = 1'b1;
        logic        busy_restart = 1'b0;
        logic [11:0] dig_first = '0;
        wait_idle(ok);
        score_in   = 32'd100;
        sample_now = 1'b1;
        @(negedge clock);
        sample_now = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clock);
            if (update_pulse) begin
                cnt++;
                if (first < 0) begin
                    first     = k;
                    dig_first = {bcd_hundreds, bcd_tens, bcd_ones};
                end
            end
            if (k == 10) busy_gap = busy;
            if (k == 11) busy_restart = busy;
            sample_now = (k == 3) || (k == 6);
            if (k == 3) score_in = 32'd200;
        end
        tests_run++;
        if (cnt !== 2 || first !== 10 || dig_first !== 12'h100) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d updates first at %0d digits %h, required 2 at 10 digits 100",
                     cnt, first, dig_first);
        end
        tests_run++;
        if (busy_gap !== 1'b0 || busy_restart !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_gap: got busy %b then %b, required 0 then 1", busy_gap, busy_restart);
        end
        tests_run++;
        if ({bcd_hundreds, bcd_tens, bcd_ones} !== 12'h200) begin
            tests_failed++;
            $display("FAIL b2b_final: got %h, required 200", {bcd_hundreds, bcd_tens, bcd_ones});
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cnt = 0;
        wait_idle(ok);
        score_in   = 32'd999;
        sample_now = 1'b1;
        @(negedge clock);
        sample_now = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bcd_hundreds, bcd_tens, bcd_ones, overflow, update_pulse, busy} !== 15'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_out: got %h%h%h ovf=%b upd=%b busy=%b, required all 0",
                     bcd_hundreds, bcd_tens, bcd_ones, overflow, update_pulse, busy);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (update_pulse || {bcd_hundreds, bcd_tens, bcd_ones} != 12'h000) cnt++;
        end
        tests_run++;
        if (cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: got %0d cycles with update or digits, required 0", cnt);
        end
        run_conv(32'd999, ok);
        tests_run++;
        if (!ok || {bcd_hundreds, bcd_tens, bcd_ones, overflow} !== {12'h999, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got ok=%b %h%h%h ovf=%b, required 999 ovf=0",
                     ok, bcd_hundreds, bcd_tens, bcd_ones, overflow);
        end
    endtask

    task automatic test_seg();
        bit ok;
        logic [20:0] want;
        run_conv(32'd7, ok);
`ifdef SCORE_BCD_SEVSEG_EN
        want = {7'h7F, 7'h7F, seg_of(7)};
`else
        want = {21{1'b1}};
`endif
        tests_run++;
        if (!ok || {seg_hundreds, seg_tens, seg_ones} !== want) begin
            tests_failed++;
            $display("FAIL seg_7: got %h %h %h, required %h", seg_hundreds, seg_tens, seg_ones, want);
        end
        run_conv(32'd105, ok);
`ifdef SCORE_BCD_SEVSEG_EN
        want = {seg_of(1), seg_of(0), seg_of(5)};
`else
        want = {21{1'b1}};
`endif
        tests_run++;
        if (!ok || {seg_hundreds, seg_tens, seg_ones} !== want) begin
            tests_failed++;
            $display("FAIL seg_105: got %h %h %h, required %h", seg_hundreds, seg_tens, seg_ones, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_periodic();
        test_sample_latency();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_seg();
        tests_run++;
        if (n_updates < 8) begin
            tests_failed++;
            $display("FAIL sb_coverage: got %0d updates, required at least 8", n_updates);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
